div_seq: RTL
============

# div_seq

Iterative RV32M divide sequencer for DIV/DIVU/REM/REMU. It accepts one operation from the execute stage and runs a 32-step restoring divide on the operands. It then presents the result and destination register to the write-back path for one cycle. While it runs, `busy_o` drives the execute stage's `div_busy_i`, which suppresses execute-stage register writeback. The control unit's hold/flush aborts an operation in flight.

## Interface
- `DATA_W`, default 32: operand and result width; only 32 is supported.
- `REG_ADDR_W`, default 5: destination register address width.
- `clk` (in, 1): clock; all state changes on the rising edge.
- `rst` (in, 1): reset, synchronous, active-high.
- `start_i` (in, 1): operation request; sampled only in IDLE.
- `op_i` (in, 3): funct3 code.
  - 3'b100 = DIV, 3'b101 = DIVU, 3'b110 = REM, 3'b111 = REMU.
  - Other values: `start_i` is ignored.
- `dividend_i` (in, `DATA_W`): rs1 value.
- `divisor_i` (in, `DATA_W`): rs2 value.
- `rd_i` (in, `REG_ADDR_W`): destination register.
- `hold_flag_i` (in, 1): flush from the control unit.
- `busy_o` (out, 1): high whenever state ≠ IDLE.
- `result_valid_o` (out, 1): one-cycle result pulse.
- `rd_wr_en_o` (out, 1): equal to `result_valid_o`.
- `rd_o` (out, `REG_ADDR_W`): latched `rd_i`.
- `result_o` (out, `DATA_W`): quotient or remainder.

## Operation
- States are IDLE, CALC and DONE.
- **Reset:** state = IDLE. `busy_o`, `result_valid_o`, `rd_wr_en_o`, `rd_o`, `result_o` and the internal counter all = 0.
- **IDLE → CALC** when `start_i` is high, `op_i` is valid and `hold_flag_i` is low. On that edge the block latches:
  - op, `rd_i`;
  - |dividend| and |divisor| (absolute value only for signed ops);
  - the quotient sign, `dividend[31] ^ divisor[31]`, and the remainder sign, `dividend[31]`;
  - divisor-zero and overflow flags.
  - It then clears the 33-bit partial remainder and the 5-bit counter.
- **CALC**, once per cycle:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor.
  - If the difference is ≥ 0, keep it and set quo[0] = 1.
  - The counter increments; after the step at counter = 31, go to DONE.
- **DONE:** lasts 1 cycle, then returns to IDLE.
  - `result_valid_o = rd_wr_en_o = (state == DONE) & ~hold_flag_i`.
  - `result_o` is selected as follows:
    - Divide by zero: quotient = 32'hFFFF_FFFF; remainder = the original dividend.
    - Signed overflow (DIV/REM with dividend 32'h8000_0000 and divisor 32'hFFFF_FFFF): quotient = 32'h8000_0000; remainder = 0.
    - Otherwise the quotient is negated when signed and the quotient sign is set. The remainder is negated when signed and the remainder sign is set.
- **Flush:** if `hold_flag_i` is high in CALC or DONE, the next state is IDLE and no result is produced.
- **Start while busy:** `start_i` outside IDLE is ignored, with no queuing.
- **Hold and start together in IDLE:** the start is ignored.
- **`rst` mid-operation:** returns to IDLE, all outputs 0, no result pulse.

## Timing
- `start_i` is sampled at edge k. `busy_o` is high from cycle k+1 through cycle k+33 inclusive.
- DONE is cycle k+33, so `result_valid_o` is high for exactly that one cycle. Total latency is 33 cycles.
- A new start is accepted at edge k+34, at the earliest.
- `result_o` and `rd_o` are stable throughout DONE. Outside DONE, `result_o` holds its last value.
- The critical path is the 33-bit subtract plus the mux.

## Configuration
- `DIV_EARLY_OUT_EN` defined: divide-by-zero and signed-overflow cases go IDLE → DONE directly.
  - `busy_o` is high for 1 cycle (k+1) and `result_valid_o` pulses at k+1.
  - Result values are unchanged.
- `DIV_EARLY_OUT_EN` undefined: every operation takes the full 33 cycles. The special-case results are still forced in DONE.

## Test plan
- DIVU 100 / 7: `result_o` = 14 and `rd_o` = 5 at k+33; `busy_o` is high for 33 cycles.
- REM 32'hFFFF_FFF9 (−7) / 2: result 32'hFFFF_FFFF. DIV on the same operands: 32'hFFFF_FFFD (−3).
- Divide-by-zero, dividend 32'hFFFF_FFF6:
  - DIV 32'hFFFF_FFF6 / 0: result 32'hFFFF_FFFF.
  - REMU 32'hFFFF_FFF6 / 0: result 32'hFFFF_FFF6.
  - Valid at k+33 without the macro and at k+1 with it.
- Overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: result 32'h8000_0000. REM on the same operands: 0.
- Abort: `hold_flag_i` pulsed at cycle k+10 → IDLE at k+11 with `busy_o` = 0. No `result_valid_o` appears through k+40. A new DIVU 9/3 then returns 3.
- Collisions:
  - `start_i` held high during an operation is ignored, and only one result pulse appears.
  - `rst` asserted at k+20 zeroes all outputs on the next edge.

Source files
------------

// File: rtl/div_seq.sv
// Iterative 32-step restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow cases in one cycle.
module div_seq #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  hold_flag_i,
  output logic                  busy_o,
  output logic                  result_valid_o,
  output logic                  rd_wr_en_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0]     result_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic                    signed_q, signed_d;
  logic                    rem_op_q, rem_op_d;
  logic                    qsign_q, qsign_d;
  logic                    rsign_q, rsign_d;
  logic                    div0_q, div0_d;
  logic                    ovf_q, ovf_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]       dvs_q, dvs_d;
  logic [DATA_W-1:0]       quo_q, quo_d;
  logic [DATA_W:0]         rem_q, rem_d;
  logic [DATA_W-1:0]       orig_q, orig_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]       result_q, result_d;

  logic                    start_ok;
  logic                    op_signed;
  logic                    early_out;
  logic [DATA_W:0]         shifted;
  logic [DATA_W+1:0]       diff;
  logic [DATA_W-1:0]       res_calc;

  assign start_ok  = start_i & op_i[2] & ~hold_flag_i;
  assign op_signed = ~op_i[0];
  assign shifted   = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
  assign diff      = {1'b0, shifted} - {2'b00, dvs_q};

  // Special cases override the iterative result, so early-out needs no datapath change.
  always_comb begin
    if (rem_op_q) begin
      if (div0_q)                  res_calc = orig_q;
      else if (ovf_q)              res_calc = '0;
      else if (signed_q & rsign_q) res_calc = -rem_q[DATA_W-1:0];
      else                         res_calc = rem_q[DATA_W-1:0];
    end else begin
      if (div0_q)                  res_calc = {DATA_W{1'b1}};
      else if (ovf_q)              res_calc = MIN_NEG;
      else if (signed_q & qsign_q) res_calc = -quo_q;
      else                         res_calc = quo_q;
    end
  end

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    signed_d  = signed_q;
    rem_op_d  = rem_op_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    rd_d      = rd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    orig_d    = orig_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    early_out = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          signed_d = op_signed;
          rem_op_d = op_i[1];
          rd_d     = rd_i;
          orig_d   = dividend_i;
          qsign_d  = dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
          rsign_d  = dividend_i[DATA_W-1];
          quo_d    = (op_signed & dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
          dvs_d    = (op_signed & divisor_i[DATA_W-1]) ? -divisor_i : divisor_i;
          div0_d   = (divisor_i == '0);
          ovf_d    = op_signed & (dividend_i == MIN_NEG) & (divisor_i == {DATA_W{1'b1}});
          rem_d    = '0;
          cnt_d    = '0;
`ifdef DIV_EARLY_OUT_EN
          early_out = div0_d | ovf_d;
`endif
          state_d  = early_out ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (hold_flag_i) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[DATA_W+1]) begin
            rem_d = diff[DATA_W:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shifted;
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_d = res_calc;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      signed_q <= 1'b0;
      rem_op_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rd_q     <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      orig_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      rem_op_q <= rem_op_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      rd_q     <= rd_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      orig_q   <= orig_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign result_valid_o = (state_q == S_DONE) & ~hold_flag_i;
  assign rd_wr_en_o     = result_valid_o;
  assign rd_o           = rd_q;
  assign result_o       = (state_q == S_DONE) ? res_calc : result_q;

endmodule
